// File: rtl/upc_seq.sv
// upc_seq: microcode program-counter sequencer with a circular subroutine return stack.
// The stack wraps on overflow/underflow; sticky flags record both events.
module upc_seq #(
  parameter int PC_W   = 14,
  parameter int SPC_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              state_fetch,
  input  logic [1:0]        pcs,
  input  logic              trap,
  input  logic [PC_W-1:0]   jaddr,
  input  logic [PC_W-1:0]   dpc,
  input  logic              spush,
  input  logic              spop,
  input  logic              spcwsel,
  input  logic [PC_W-1:0]   spcw,
  input  logic              clr_flags,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   ipc,
  output logic [PC_W-1:0]   lpc,
  output logic [PC_W-1:0]   spc,
  output logic [SPC_AW-1:0] spcptr,
  output logic [SPC_AW:0]   spc_depth,
  output logic              spc_ovf,
  output logic              spc_unf
);
  localparam int DEPTH = 1 << SPC_AW;
  localparam logic [SPC_AW:0] FULL = (SPC_AW+1)'(DEPTH);
  logic [PC_W-1:0]   stack_q [DEPTH];
  logic [PC_W-1:0]   pc_q, pc_d, lpc_q, lpc_d, npc, top, wdata;
  logic [SPC_AW-1:0] ptr_q, ptr_d, waddr;
  logic [SPC_AW:0]   depth_q, depth_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              active, push, pop, repl, full, empty, we;
  assign ipc = pc_q + PC_W'(1);
  assign top = stack_q[ptr_q];
  always_comb begin
    active  = state_fetch & ~trap;
    push    = active & spush & ~spop;
    pop     = active & spop & ~spush;
    repl    = active & spush & spop;
    full    = depth_q == FULL;
    empty   = depth_q == '0;
    wdata   = spcwsel ? spcw : ipc;
    npc     = trap ? '0 : pcs == 2'd0 ? top : pcs == 2'd1 ? jaddr : pcs == 2'd2 ? dpc : ipc;
    pc_d    = state_fetch ? npc : pc_q;
    lpc_d   = state_fetch ? pc_q : lpc_q;
    ptr_d   = push ? ptr_q + SPC_AW'(1) : pop ? ptr_q - SPC_AW'(1) : ptr_q;
    depth_d = (push & ~full) ? depth_q + (SPC_AW+1)'(1) :
              (pop & ~empty) ? depth_q - (SPC_AW+1)'(1) : depth_q;
    // a set condition in the same cycle beats clr_flags
    ovf_d   = (push & full) | (ovf_q & ~clr_flags);
    unf_d   = (pop & empty) | (unf_q & ~clr_flags);
    we      = push | repl;
    waddr   = push ? ptr_q + SPC_AW'(1) : ptr_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      lpc_q   <= '0;
      ptr_q   <= '1;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      lpc_q   <= lpc_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  // stack contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) stack_q[waddr] <= wdata;
  end
  assign pc        = pc_q;
  assign lpc       = lpc_q;
  assign spc       = top;
  assign spcptr    = ptr_q;
  assign spc_depth = depth_q;
  assign spc_ovf   = ovf_q;
  assign spc_unf   = unf_q;
endmodule

// File: tb/tb_upc_seq.sv
// tb_upc_seq: vector table, directed stack corner cases and random run against a behavioural model.
module tb_upc_seq;
  logic        clk, reset, state_fetch, trap, spush, spop, spcwsel, clr_flags;
  logic [1:0]  pcs;
  logic [13:0] jaddr, dpc, spcw, pc, ipc, lpc, spc;
  logic [4:0]  spcptr;
  logic [5:0]  spc_depth;
  logic        spc_ovf, spc_unf;
  int n_chk = 0, n_fail = 0;
  int m_pc, m_lpc, m_ptr, m_depth;
  bit m_ovf, m_unf;
  int m_mem [32];
  bit m_known [32];

  upc_seq dut (
    .clk(clk), .reset(reset), .state_fetch(state_fetch), .pcs(pcs), .trap(trap),
    .jaddr(jaddr), .dpc(dpc), .spush(spush), .spop(spop), .spcwsel(spcwsel),
    .spcw(spcw), .clr_flags(clr_flags), .pc(pc), .ipc(ipc), .lpc(lpc), .spc(spc),
    .spcptr(spcptr), .spc_depth(spc_depth), .spc_ovf(spc_ovf), .spc_unf(spc_unf)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    bit sf; int pcs; bit trap; int jaddr; int dpc; bit spush; bit spop; bit sel; int spcw; bit clr;
    int e_pc; int e_lpc; int e_spc; int e_ptr; int e_depth; bit e_ovf; bit e_unf;
  } vec_t;
  vec_t vecs [$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_lpc = 0; m_ptr = 31; m_depth = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step();
    int ipc_v, npc, data;
    bit oset, uset;
    oset = 0; uset = 0;
    if (reset) begin model_reset(); return; end
    if (state_fetch) begin
      ipc_v = (m_pc + 1) % 16384;
      data = spcwsel ? int'(spcw) : ipc_v;
      if (trap) npc = 0;
      else if (pcs == 0) npc = m_mem[m_ptr];
      else if (pcs == 1) npc = int'(jaddr);
      else if (pcs == 2) npc = int'(dpc);
      else npc = ipc_v;
      if (!trap) begin
        if (spush && spop) begin
          m_mem[m_ptr] = data; m_known[m_ptr] = 1;
        end else if (spush) begin
          m_ptr = (m_ptr + 1) % 32;
          m_mem[m_ptr] = data; m_known[m_ptr] = 1;
          if (m_depth == 32) oset = 1; else m_depth++;
        end else if (spop) begin
          m_ptr = (m_ptr + 31) % 32;
          if (m_depth == 0) uset = 1; else m_depth--;
        end
      end
      m_lpc = m_pc;
      m_pc = npc;
    end
    m_ovf = oset | (m_ovf & !clr_flags);
    m_unf = uset | (m_unf & !clr_flags);
  endtask

  task automatic check_model();
    chk("pc", int'(pc), m_pc);
    chk("ipc", int'(ipc), (m_pc + 1) % 16384);
    chk("lpc", int'(lpc), m_lpc);
    chk("spcptr", int'(spcptr), m_ptr);
    chk("depth", int'(spc_depth), m_depth);
    chk("ovf", int'(spc_ovf), int'(m_ovf));
    chk("unf", int'(spc_unf), int'(m_unf));
    if (m_known[m_ptr]) chk("spc", int'(spc), m_mem[m_ptr]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    state_fetch = 0; pcs = 0; trap = 0; jaddr = 0; dpc = 0; spush = 0; spop = 0;
    spcwsel = 0; spcw = 0; clr_flags = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    #1;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic push_val(input int v, input bit clr);
    idle_inputs();
    state_fetch = 1; pcs = 3; spush = 1; spcwsel = 1; spcw = 14'(v); clr_flags = clr;
    cycle();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    foreach (m_known[i]) m_known[i] = 0;
    #12;
    chk("rst_pc", int'(pc), 0);
    chk("rst_lpc", int'(lpc), 0);
    chk("rst_ptr", int'(spcptr), 31);
    chk("rst_depth", int'(spc_depth), 0);
    chk("rst_flags", int'({spc_ovf, spc_unf}), 0);
    @(negedge clk);
    reset = 0;

    // sf pcs trap jaddr dpc push pop sel spcw clr | pc lpc spc ptr depth ovf unf
    vecs.push_back('{1, 3, 0, 0,      0,     0, 0, 0, 0,      0, 'h0001, 'h0000, -1,      31, 0, 0, 0});
    vecs.push_back('{1, 3, 0, 0,      0,     0, 0, 0, 0,      0, 'h0002, 'h0001, -1,      31, 0, 0, 0});
    vecs.push_back('{1, 3, 0, 0,      0,     0, 0, 0, 0,      0, 'h0003, 'h0002, -1,      31, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 'h3FFF, 0,     0, 0, 0, 0,      0, 'h3FFF, 'h0003, -1,      31, 0, 0, 0});
    vecs.push_back('{1, 3, 0, 0,      0,     0, 0, 0, 0,      0, 'h0000, 'h3FFF, -1,      31, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 'h0010, 0,     0, 0, 0, 0,      0, 'h0010, 'h0000, -1,      31, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 'h0200, 0,     1, 0, 0, 0,      0, 'h0200, 'h0010, 'h0011, 0,  1, 0, 0});
    vecs.push_back('{1, 0, 0, 0,      0,     0, 1, 0, 0,      0, 'h0011, 'h0200, -1,      31, 0, 0, 0});
    vecs.push_back('{1, 3, 0, 0,      0,     1, 0, 1, 'h0055, 0, 'h0012, 'h0011, 'h0055, 0,  1, 0, 0});
    vecs.push_back('{1, 0, 0, 0,      0,     1, 1, 1, 'h0AAA, 0, 'h0055, 'h0012, 'h0AAA, 0,  1, 0, 0});
    vecs.push_back('{1, 1, 1, 'h0123, 0,     1, 0, 0, 0,      0, 'h0000, 'h0055, 'h0AAA, 0,  1, 0, 0});
    vecs.push_back('{0, 1, 0, 'h0123, 0,     0, 0, 0, 0,      0, 'h0000, 'h0055, 'h0AAA, 0,  1, 0, 0});
    vecs.push_back('{0, 3, 0, 0,      0,     1, 0, 1, 'h0777, 0, 'h0000, 'h0055, 'h0AAA, 0,  1, 0, 0});
    vecs.push_back('{1, 2, 0, 0,      'h777, 0, 0, 0, 0,      0, 'h0777, 'h0000, 'h0AAA, 0,  1, 0, 0});
    vecs.push_back('{1, 3, 1, 0,      0,     0, 1, 0, 0,      0, 'h0000, 'h0777, 'h0AAA, 0,  1, 0, 0});
    foreach (vecs[i]) begin
      state_fetch = vecs[i].sf; pcs = 2'(vecs[i].pcs); trap = vecs[i].trap;
      jaddr = 14'(vecs[i].jaddr); dpc = 14'(vecs[i].dpc); spush = vecs[i].spush;
      spop = vecs[i].spop; spcwsel = vecs[i].sel; spcw = 14'(vecs[i].spcw);
      clr_flags = vecs[i].clr;
      cycle();
      chk($sformatf("v%0d_pc", i), int'(pc), vecs[i].e_pc);
      chk($sformatf("v%0d_lpc", i), int'(lpc), vecs[i].e_lpc);
      chk($sformatf("v%0d_ptr", i), int'(spcptr), vecs[i].e_ptr);
      chk($sformatf("v%0d_depth", i), int'(spc_depth), vecs[i].e_depth);
      chk($sformatf("v%0d_flags", i), int'({spc_ovf, spc_unf}), int'({vecs[i].e_ovf, vecs[i].e_unf}));
      if (vecs[i].e_spc >= 0) chk($sformatf("v%0d_spc", i), int'(spc), vecs[i].e_spc);
    end

    // fill, overflow, set-beats-clear, wrap back down
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      push_val(k, 0);
      if (k == 32) begin
        chk("full_depth", int'(spc_depth), 32);
        chk("full_ovf", int'(spc_ovf), 0);
        chk("full_spc", int'(spc), 32);
      end
    end
    chk("ovf_set", int'(spc_ovf), 1);
    chk("ovf_depth", int'(spc_depth), 32);
    chk("ovf_spc", int'(spc), 33);
    chk("ovf_ptr", int'(spcptr), 0);
    push_val(34, 1);
    chk("ovf_set_wins", int'(spc_ovf), 1);
    idle_inputs();
    state_fetch = 1; pcs = 3; spop = 1;
    for (int k = 0; k < 31; k++) cycle();
    chk("deep_spc", int'(spc), 3);
    chk("deep_depth", int'(spc_depth), 1);
    idle_inputs();
    clr_flags = 1;
    cycle();
    chk("ovf_clr", int'(spc_ovf), 0);

    // asynchronous reset in the middle of a push burst
    push_val(100, 0);
    push_val(101, 0);
    #3;
    reset = 1;
    #1;
    model_reset();
    chk("arst_pc", int'(pc), 0);
    chk("arst_ptr", int'(spcptr), 31);
    chk("arst_depth", int'(spc_depth), 0);
    idle_inputs();
    @(negedge clk);
    reset = 0;
    state_fetch = 1; pcs = 3; spop = 1;
    cycle();
    chk("unf_set", int'(spc_unf), 1);
    chk("unf_ptr", int'(spcptr), 30);
    chk("unf_depth", int'(spc_depth), 0);

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      state_fetch = ($urandom % 4) != 0;
      pcs = 2'($urandom % 4);
      trap = ($urandom % 8) == 0;
      jaddr = 14'($urandom); dpc = 14'($urandom); spcw = 14'($urandom);
      spush = (n % 200 < 100) ? ($urandom % 3) != 0 : ($urandom % 3) == 0;
      spop = (n % 200 < 100) ? ($urandom % 4) == 0 : ($urandom % 2) == 0;
      spcwsel = $urandom % 2;
      clr_flags = ($urandom % 10) == 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/upc_seq.md
Name: upc_seq

Overview:
- Microcode program-counter sequencer.
- Holds the micro PC, computes the next PC on each fetch, keeps the last PC and the incremented PC, and maintains the subroutine return stack (SPC).
- Sits directly upstream of the old-PC save shifter: its pc output feeds that shifter, and its state_fetch advance strobe is the same one the shifter uses.

Parameters:
- PC_W, 14, micro-PC width in bits.
- SPC_AW, 5, SPC pointer width; stack depth = 2**SPC_AW (32).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- state_fetch  in  1  advance strobe; PC, LPC and stack update only in cycles where this is 1.
- pcs  in  2  next-PC select: 0 = SPC top, 1 = jump address, 2 = dispatch address, 3 = ipc.
- trap  in  1  forces next PC to 0; overrides pcs, spush and spop.
- jaddr  in  PC_W  jump address field from the instruction.
- dpc  in  PC_W  dispatch target.
- spush  in  1  push onto SPC at this fetch.
- spop  in  1  pop SPC at this fetch.
- spcwsel  in  1  push data select: 0 = ipc (return address), 1 = spcw.
- spcw  in  PC_W  external push data.
- clr_flags  in  1  clears the sticky stack flags.
- pc  out  PC_W  current micro PC.
- ipc  out  PC_W  pc+1, combinational.
- lpc  out  PC_W  PC before the most recent fetch.
- spc  out  PC_W  stack top, combinational read of entry[spcptr].
- spcptr  out  SPC_AW  index of top entry.
- spc_depth  out  SPC_AW+1  number of valid entries, 0..2**SPC_AW.
- spc_ovf  out  1  sticky: push occurred while the stack was full.
- spc_unf  out  1  sticky: pop occurred while the stack was empty.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - pc = 0, lpc = 0, spcptr = all ones, spc_depth = 0, spc_ovf = 0, spc_unf = 0.
  - Stack array contents are not reset; spc shows whatever entry[all ones] holds.
- ipc = (pc + 1) mod 2**PC_W; 0x3FFF wraps to 0x0000.
- Next PC (npc):
  - trap = 1: npc = 0.
  - Otherwise by pcs: 0 -> spc, 1 -> jaddr, 2 -> dpc, 3 -> ipc.
  - spc here is the top value before any pop in the same cycle.
- Fetch cycle (state_fetch = 1): pc <= npc, lpc <= pc (old value). One-cycle latency: the new pc is visible the cycle after the strobe.
- state_fetch = 0: pc, lpc, stack, pointer and depth all hold; spush, spop and trap are ignored.
- Stack operations, only when state_fetch = 1 and trap = 0:
  - Push data: spcwsel ? spcw : ipc, with ipc taken from the pre-fetch pc.
  - Push only: spcptr <= spcptr + 1 (mod depth), entry[spcptr+1] <= data, spc_depth + 1 saturating at 2**SPC_AW.
  - Push when spc_depth = max: pointer still advances, overwriting the oldest entry; depth stays at max; spc_ovf <= 1.
  - Pop only: spcptr <= spcptr − 1 (mod depth); spc_depth − 1.
  - Pop when spc_depth = 0: pointer still decrements (wraps); depth stays 0; spc_unf <= 1.
  - Push and pop together: entry[spcptr] <= data; pointer, depth and flags unchanged (replace top).
  - trap = 1 with a fetch: spush and spop are suppressed; only pc and lpc update.
- Flags:
  - clr_flags clears spc_ovf and spc_unf.
  - If a set condition and clr_flags occur in the same cycle, set wins.
- The stack write and the combinational spc read of the same entry in one cycle: spc shows the old value; the new value appears after the edge.

Test Plan:
- Reset, then 3 fetches with pcs = 3 -> pc 0,1,2,3 and lpc 0,0,1,2; force pc = 0x3FFF then fetch -> pc = 0x0000, lpc = 0x3FFF.
- At pc = 0x0010, fetch with pcs = 1, jaddr = 0x0200, spush = 1, spcwsel = 0 -> pc = 0x0200, spc = 0x0011, depth = 1. Then fetch with pcs = 0, spop = 1 -> pc = 0x0011, depth = 0, spc_unf = 0.
- 33 consecutive pushes of values 1..33 -> after push 32 depth = 32, spc_ovf = 0; after push 33 spc_ovf = 1, depth = 32, spc = 33, oldest entry (value 1) overwritten; then clr_flags -> spc_ovf = 0.
- Stack top = 0x0055, fetch with spush = spop = 1, spcwsel = 1, spcw = 0x0AAA, pcs = 0 -> pc = 0x0055, spc = 0x0AAA, spcptr and depth unchanged.
- Fetch with trap = 1, pcs = 1, jaddr = 0x0123, spush = 1 -> pc = 0, depth unchanged; state_fetch = 0 with pcs = 1 -> pc holds.
- Assert reset asynchronously between clock edges during a push sequence -> outputs take reset values immediately, without waiting for a clock edge; pop on the empty stack after release -> spc_unf = 1, spcptr = all ones − 1.
